fuel_sensor_sampler: RTL and testbench
======================================

FUEL_SENSOR_SAMPLER -- requirements
Module: fuel_sensor_sampler

Interface
REQ-001 Parameter PULSES_PER_UNIT, default 8, SHALL set the number of wheel pulses that make one distance unit (legal range 1..255).
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the sample FIFO depth (power of two, at least 2).
REQ-003 clk  input  1  SHALL be the single rising-edge clock for all state.
REQ-004 nreset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 enable  input  1  SHALL gate accumulation: when low, accumulators hold cleared and ticks are ignored.
REQ-006 wheel_pulse  input  1  SHALL carry the asynchronous odometer pulse; each rising edge is one pulse.
REQ-007 fuel_level_in  input  5  SHALL carry the tank level, sampled on tick.
REQ-008 sample_tick  input  1  SHALL be a one-cycle strobe that closes a measurement window.
REQ-009 out_valid  output  1  SHALL be high while the FIFO holds at least one sample.
REQ-010 out_ready  input  1  SHALL be the consumer's acceptance signal.
REQ-011 out_distance  output  4; out_fuel  output  5; out_overflow  output  1 -- these SHALL present the head sample.
REQ-012 drop_count  output  8  SHALL count samples lost to a full FIFO.

Function
REQ-013 wheel_pulse SHALL pass through a 2-flop synchronizer; a rising edge SHALL be detected on the synchronized signal, one pulse event per edge.
REQ-014 A prescaler SHALL count pulse events; on reaching PULSES_PER_UNIT it SHALL wrap to 0 and increment the distance accumulator by 1.
REQ-015 The distance accumulator SHALL saturate at 15; an increment attempted at 15 SHALL set the window overflow flag.
REQ-016 On sample_tick with enable high, {distance accumulator, fuel_level_in, overflow flag} SHALL be pushed to the FIFO in the same cycle.
REQ-017 On that tick the accumulator and overflow flag SHALL clear; the prescaler SHALL NOT clear.
REQ-018 A pulse event in the tick cycle SHALL count toward the new window.
REQ-019 Handshake: a pop occurs on out_valid && out_ready; the output data SHALL be held stable while out_valid && !out_ready.
REQ-020 Output latency from tick to out_valid on an empty FIFO SHALL be one cycle; the FIFO SHALL be registered and non-bypass.
REQ-021 If the FIFO is full and a pop occurs in the tick cycle, the push SHALL be accepted.
REQ-022 If the FIFO is full with no pop, the sample SHALL be dropped and drop_count SHALL increment, saturating at 255.
REQ-023 In a dropped-sample case the accumulator SHALL still clear.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 Deasserting enable SHALL clear the accumulator, prescaler and overflow flag, and SHALL NOT flush the FIFO; pops SHALL continue while enable is low.

Reset
REQ-026 While nreset is low: out_valid=0, out_distance=0, out_fuel=0, out_overflow=0, drop_count=0, FIFO empty, accumulator, prescaler and synchronizer flops =0.
REQ-027 Reset mid-window SHALL discard the partial window and all queued samples.
REQ-028 The first pulse after reset release SHALL require a synchronized 0->1 transition.

Configuration
REQ-029 With FUEL_SAMPLER_GLITCH_FILTER_EN defined, a pulse event SHALL require the synchronized input to stay high for 3 consecutive cycles after a low; shorter highs SHALL be ignored.
REQ-030 Without FUEL_SAMPLER_GLITCH_FILTER_EN, the REQ-013 edge detect alone SHALL apply, and the filter logic SHALL be absent.

Structure
REQ-031 Shared package fuel_gauge_pkg SHALL hold the DIST_W=4 and FUEL_W=5 constants and the fuel_sample_t record {distance, fuel, overflow}.
REQ-032 The FIFO SHALL be a separate sub-module sample_fifo, parameterized by depth and carrying fuel_sample_t.

Verification
REQ-033 PULSES_PER_UNIT=8, 24 pulses, tick, out_ready=1 -> one sample: distance=3, fuel=level at tick, overflow=0.
REQ-034 130 pulses, then tick -> distance=15, overflow=1; the next window starts at 0 with overflow=0.
REQ-035 out_ready=0, 6 ticks at depth 4 -> 4 samples queued and drop_count=2; then out_ready=1 -> the 4 samples drain in order, with data stable while stalled.
REQ-036 FIFO full, tick coincident with a pop -> no drop, count stays 4, drop_count unchanged.
REQ-037 nreset asserted with 2 queued samples and a partial window -> all outputs 0 immediately; after release the first tick yields distance counted from 0.
REQ-038 With FUEL_SAMPLER_GLITCH_FILTER_EN, 1- and 2-cycle highs -> no count, and a 3-cycle high -> one count; without the macro -> all three count.

Source files
------------

// File: rtl/fuel_gauge_pkg.sv
// Shared widths and the sample record passed from the sampler core through its FIFO.
// Used by fuel_sensor_sampler, its output interface and sample_fifo.
package fuel_gauge_pkg;

  localparam int DIST_W = 4;
  localparam int FUEL_W = 5;
  localparam int DROP_W = 8;

  localparam logic [DIST_W-1:0] DIST_MAX = '1;

  typedef struct packed {
    logic [DIST_W-1:0] distance;
    logic [FUEL_W-1:0] fuel;
    logic              overflow;
  } fuel_sample_t;

  // Saturating increment for the lost-sample counter.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fuel_sensor_sampler_if.sv
// Valid/ready output channel of the fuel sensor sampler carrying one fuel_sample_t.
// master drives the sample and valid, slave drives ready.
interface fuel_sensor_sampler_if;
  import fuel_gauge_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [DIST_W-1:0] out_distance;
  logic [FUEL_W-1:0] out_fuel;
  logic              out_overflow;

  modport master (
    output out_valid,
    output out_distance,
    output out_fuel,
    output out_overflow,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_distance,
    input  out_fuel,
    input  out_overflow,
    output out_ready
  );

endinterface

// File: rtl/sample_fifo.sv
// Registered, non-bypass sample FIFO; DEPTH must be a power of two (>= 2) so pointers wrap naturally.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sample_fifo
  import fuel_gauge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         push,
  input  fuel_sample_t wr_data,
  input  logic         pop,
  output fuel_sample_t rd_data,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fuel_sample_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the empty count hides stale entries and rd_data is forced to 0.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fuel_sensor_sampler.sv
// Odometer/fuel sampler: counts synchronized wheel pulses into distance units per window and queues
// {distance, fuel, overflow} on each sample_tick. Optional glitch filter: FUEL_SAMPLER_GLITCH_FILTER_EN.
module fuel_sensor_sampler
  import fuel_gauge_pkg::*;
#(
  parameter int PULSES_PER_UNIT = 8,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  enable,
  input  logic                  wheel_pulse,
  input  logic [FUEL_W-1:0]     fuel_level_in,
  input  logic                  sample_tick,
  fuel_sensor_sampler_if.master out_if,
  output logic [DROP_W-1:0]     drop_count
);

  localparam logic [7:0] PRESC_LAST = 8'(PULSES_PER_UNIT - 1);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              pulse_event;
  logic [7:0]        presc_q, presc_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic              ovf_q, ovf_d;
  logic              unit_inc;
  logic [DROP_W-1:0] drop_count_q, drop_count_d;

  logic              tick_push;
  logic              fifo_empty, fifo_full, fifo_pop;
  fuel_sample_t      push_sample, head;

  always_comb begin
    sync1_d = wheel_pulse;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef FUEL_SAMPLER_GLITCH_FILTER_EN
  // Count consecutive high cycles; the event fires once, on the third high cycle after a low.
  logic [1:0] high_cnt_q, high_cnt_d;

  always_comb begin
    high_cnt_d  = high_cnt_q;
    pulse_event = 1'b0;
    if (!sync2_q) begin
      high_cnt_d = 2'd0;
    end else if (high_cnt_q != 2'd3) begin
      high_cnt_d  = high_cnt_q + 2'd1;
      pulse_event = (high_cnt_q == 2'd2);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) high_cnt_q <= 2'd0;
    else         high_cnt_q <= high_cnt_d;
  end
`else
  logic sync_prev_q, sync_prev_d;

  always_comb begin
    sync_prev_d = sync2_q;
    pulse_event = sync2_q & ~sync_prev_q;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) sync_prev_q <= 1'b0;
    else         sync_prev_q <= sync_prev_d;
  end
`endif

  assign tick_push = sample_tick & enable;

  // The tick-cycle pulse belongs to the new window, so the closing sample uses dist_q/ovf_q as-is.
  always_comb begin
    presc_d  = presc_q;
    dist_d   = dist_q;
    ovf_d    = ovf_q;
    unit_inc = 1'b0;
    if (!enable) begin
      presc_d = '0;
      dist_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      if (pulse_event) begin
        if (presc_q == PRESC_LAST) begin
          presc_d  = '0;
          unit_inc = 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      if (tick_push) begin
        dist_d = DIST_W'(unit_inc);
        ovf_d  = 1'b0;
      end else if (unit_inc) begin
        if (dist_q == DIST_MAX) ovf_d  = 1'b1;
        else                    dist_d = dist_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      presc_q <= '0;
      dist_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      dist_q  <= dist_d;
      ovf_q   <= ovf_d;
    end
  end

  assign push_sample = '{distance: dist_q, fuel: fuel_level_in, overflow: ovf_q};
  assign fifo_pop    = ~fifo_empty & out_if.out_ready;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nreset  (nreset),
    .push    (tick_push),
    .wr_data (push_sample),
    .pop     (fifo_pop),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_comb begin
    drop_count_d = drop_count_q;
    if (tick_push && fifo_full && !fifo_pop) begin
      drop_count_d = sat_inc(drop_count_q);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) drop_count_q <= '0;
    else         drop_count_q <= drop_count_d;
  end

  assign drop_count          = drop_count_q;
  assign out_if.out_valid    = ~fifo_empty;
  assign out_if.out_distance = head.distance;
  assign out_if.out_fuel     = head.fuel;
  assign out_if.out_overflow = head.overflow;

endmodule

// File: tb/tb_fuel_sensor_sampler.sv
// Self-checking bench for fuel_sensor_sampler: randomized pulse/fuel stimulus against a model that
// derives each window's distance from total pulse counts and keeps expected samples in a queue.
module tb_fuel_sensor_sampler;
  import fuel_gauge_pkg::*;

  localparam int PPU   = 8;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              nreset;
  logic              enable;
  logic              wheel_pulse;
  logic [FUEL_W-1:0] fuel_level_in;
  logic              sample_tick;
  logic [DROP_W-1:0] drop_count;

  fuel_sensor_sampler_if bus ();

  fuel_sensor_sampler #(
    .PULSES_PER_UNIT (PPU),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk           (clk),
    .nreset        (nreset),
    .enable        (enable),
    .wheel_pulse   (wheel_pulse),
    .fuel_level_in (fuel_level_in),
    .sample_tick   (sample_tick),
    .out_if        (bus),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pulses counted since enable/reset, unit count at window start, queued samples.
  int           total_ev;
  int           win_start;
  int           exp_drops;
  fuel_sample_t exp_q[$];

  function automatic fuel_sample_t window_sample(input logic [FUEL_W-1:0] f);
    int units;
    fuel_sample_t s;
    units      = total_ev / PPU - win_start;
    s.distance = (units > 15) ? 4'd15 : 4'(units);
    s.fuel     = f;
    s.overflow = (units > 15);
    return s;
  endfunction

  function automatic fuel_sample_t head_obs();
    return '{bus.out_distance, bus.out_fuel, bus.out_overflow};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_clear();
    total_ev  = 0;
    win_start = 0;
    exp_drops = 0;
    exp_q.delete();
  endtask

  task automatic send_pulses(input int n, input int hi);
    for (int i = 0; i < n; i++) begin
      wheel_pulse = 1'b1;
      cyc(hi);
      wheel_pulse = 1'b0;
      cyc(3);
    end
    if (enable) total_ev += n;
    cyc(6);
  endtask

  task automatic do_tick(input bit with_pop);
    logic [FUEL_W-1:0] f;
    fuel_sample_t s;
    f = FUEL_W'($urandom);
    s = window_sample(f);
    fuel_level_in = f;
    sample_tick   = 1'b1;
    if (with_pop) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || exp_q.size() == 0 || head_obs() !== exp_q[0])
        $display("FAIL tick_pop_head: got valid=%b sample=%h, expected valid=1 sample=%h",
                 bus.out_valid, head_obs(), (exp_q.size() > 0) ? exp_q[0] : fuel_sample_t'('0));
      else n_pass++;
      bus.out_ready = 1'b1;
    end
    cyc(1);
    sample_tick   = 1'b0;
    bus.out_ready = 1'b0;
    if (with_pop && exp_q.size() > 0) void'(exp_q.pop_front());
    if (exp_q.size() < DEPTH) exp_q.push_back(s);
    else if (exp_drops < 255) exp_drops++;
    win_start = total_ev / PPU;
  endtask

  task automatic drain(input string tag);
    int waited;
    while (exp_q.size() > 0) begin
      waited = 0;
      while (bus.out_valid !== 1'b1 && waited < 20) begin
        cyc(1);
        waited++;
      end
      if (bus.out_valid !== 1'b1) begin
        n_checks++;
        $display("FAIL %s_timeout: out_valid=%b, expected 1 within 20 cycles", tag, bus.out_valid);
        exp_q.delete();
        break;
      end
      repeat ($urandom_range(0, 2)) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || head_obs() !== exp_q[0])
          $display("FAIL %s_stall: got valid=%b sample=%h, expected valid=1 sample=%h",
                   tag, bus.out_valid, head_obs(), exp_q[0]);
        else n_pass++;
        cyc(1);
      end
      n_checks++;
      if (bus.out_valid !== 1'b1 || head_obs() !== exp_q[0])
        $display("FAIL %s_data: got valid=%b sample=%h, expected valid=1 sample=%h",
                 tag, bus.out_valid, head_obs(), exp_q[0]);
      else n_pass++;
      bus.out_ready = 1'b1;
      cyc(1);
      bus.out_ready = 1'b0;
      void'(exp_q.pop_front());
    end
    n_checks++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL %s_empty: got out_valid=%b, expected 0", tag, bus.out_valid);
    else n_pass++;
  endtask

  task automatic check_zero_outputs(input string tag);
    n_checks++;
    if ({bus.out_valid, bus.out_distance, bus.out_fuel, bus.out_overflow, drop_count} !== '0)
      $display("FAIL %s: got valid=%b dist=%0d fuel=%0d ovf=%b drops=%0d, expected all 0",
               tag, bus.out_valid, bus.out_distance, bus.out_fuel, bus.out_overflow, drop_count);
    else n_pass++;
  endtask

  task automatic do_reset();
    enable      = 1'b0;
    wheel_pulse = 1'b0;
    sample_tick = 1'b0;
    nreset      = 1'b0;
    cyc(2);
    nreset      = 1'b1;
    model_clear();
    cyc(2);
  endtask

  task automatic test_reset();
    cyc(2);
    check_zero_outputs("reset_hold");
    nreset = 1'b1;
    cyc(2);
    check_zero_outputs("reset_release");
    enable = 1'b1;
    cyc(2);
  endtask

  task automatic test_basic();
    send_pulses(24, 3);
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL basic_pre_valid: got %b, expected 0", bus.out_valid);
    else n_pass++;
    do_tick(0);
    n_checks++;
    if (bus.out_valid !== 1'b1) $display("FAIL basic_latency: got out_valid=%b one cycle after tick, expected 1", bus.out_valid);
    else n_pass++;
    drain("basic");
  endtask

  task automatic test_overflow();
    send_pulses(130, 3);
    do_tick(0);
    do_tick(0);
    drain("overflow");
  endtask

  task automatic test_random();
    for (int w = 0; w < 6; w++) begin
      send_pulses($urandom_range(0, 30), 3);
      do_tick(0);
      if (exp_q.size() >= 2 || $urandom_range(0, 1) == 1) drain("random");
    end
    drain("random_end");
  endtask

  task automatic test_full_drop();
    for (int t = 0; t < 6; t++) begin
      send_pulses($urandom_range(0, 12), 3);
      do_tick(0);
    end
    n_checks++;
    if (drop_count !== 8'(exp_drops))
      $display("FAIL full_drop_count: got %0d, expected %0d", drop_count, exp_drops);
    else n_pass++;
    drain("full_drop");
  endtask

  task automatic test_full_pop();
    for (int t = 0; t < DEPTH; t++) begin
      send_pulses($urandom_range(0, 10), 3);
      do_tick(0);
    end
    do_tick(1);
    n_checks++;
    if (drop_count !== 8'(exp_drops))
      $display("FAIL full_pop_drops: got %0d, expected %0d", drop_count, exp_drops);
    else n_pass++;
    drain("full_pop");
  endtask

  task automatic test_enable_low();
    send_pulses(10, 3);
    do_tick(0);
    send_pulses(5, 3);
    enable    = 1'b0;
    total_ev  = 0;
    win_start = 0;
    cyc(2);
    send_pulses(9, 3);
    sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
    cyc(2);
    drain("enable_low");
    enable = 1'b1;
    cyc(2);
    send_pulses(8, 3);
    do_tick(0);
    drain("enable_resume");
  endtask

  task automatic test_tick_pulse();
    int k;
    do_tick(0);
    drain("tick_pulse_flush");
    k = (PPU - 1) - (total_ev % PPU);
    send_pulses(k, 3);
    wheel_pulse = 1'b1;
`ifdef FUEL_SAMPLER_GLITCH_FILTER_EN
    cyc(4);
`else
    cyc(2);
`endif
    do_tick(0);
    total_ev += 1;
    wheel_pulse = 1'b0;
    cyc(8);
    do_tick(0);
    drain("tick_pulse");
  endtask

  task automatic test_reset_mid();
    for (int t = 0; t < 2; t++) begin
      send_pulses($urandom_range(0, 10), 3);
      do_tick(0);
    end
    send_pulses(12, 3);
    nreset = 1'b0;
    #1;
    check_zero_outputs("reset_mid");
    cyc(3);
    check_zero_outputs("reset_mid_hold");
    nreset = 1'b1;
    model_clear();
    cyc(2);
    send_pulses(16, 3);
    do_tick(0);
    drain("reset_mid_after");
  endtask

  task automatic test_glitch();
    do_reset();
    enable = 1'b1;
    cyc(2);
    for (int hi = 1; hi <= 3; hi++) begin
      wheel_pulse = 1'b1;
      cyc(hi);
      wheel_pulse = 1'b0;
      cyc(4);
    end
    cyc(6);
`ifdef FUEL_SAMPLER_GLITCH_FILTER_EN
    total_ev += 1;
`else
    total_ev += 3;
`endif
    send_pulses(6, 3);
    do_tick(0);
    drain("glitch");
  endtask

  initial begin
    nreset        = 1'b0;
    enable        = 1'b0;
    wheel_pulse   = 1'b0;
    sample_tick   = 1'b0;
    fuel_level_in = '0;
    bus.out_ready = 1'b0;
    model_clear();

    test_reset();
    test_basic();
    test_overflow();
    test_random();
    test_full_drop();
    test_full_pop();
    test_enable_low();
    test_tick_pulse();
    test_reset_mid();
    test_glitch();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

endmodule
